orlink_crc_engine: RTL and testbench

- Parametrised, frame-aware CRC generator/checker for the orlink link layer, generalising the fixed 16-bit byte CRC.
- Accepts DATA_BYTES-wide beats over a valid/ready handshake and folds them in one byte per clock, with configurable width, polynomial, init, reflection and final XOR.
- Reports the CRC on end-of-frame and also flags a residue match, so one block serves both TX generation and RX checking.

---
 rtl/orlink_crc_engine.sv | 112 +++++++++++
 tb/tb_orlink_crc_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/orlink_crc_engine.sv
// orlink_crc_engine: frame-aware parametrised CRC generator/checker folding one byte per clock
module orlink_crc_engine #(
  parameter int          CRC_W      = 16,
  parameter logic [31:0] POLY       = 32'h1021,
  parameter logic [31:0] INIT       = 32'hFFFF,
  parameter int          REFIN      = 0,
  parameter int          REFOUT     = 0,
  parameter logic [31:0] XOROUT     = 32'h0000,
  parameter logic [31:0] RESIDUE    = 32'h0000,
  parameter int          DATA_BYTES = 4,
  localparam int         NW         = $clog2(DATA_BYTES) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic                    in_sof,
  input  logic                    in_eof,
  input  logic [NW-1:0]           in_nbytes,
  input  logic                    in_abort,
  output logic                    busy,
  output logic                    crc_valid,
  output logic [CRC_W-1:0]        crc_out,
  output logic                    crc_ok
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CRC_W-1:0] P  = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] I0 = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XO = XOROUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RS = RESIDUE[CRC_W-1:0];
  state_t                  state;
  logic [8*DATA_BYTES-1:0] data_q;
  logic [NW-1:0]           n_q, idx_q, n_in;
  logic                    eof_q, upd_q, in_frame, last;
  logic [CRC_W-1:0]        crc_q, crc_nx;
  logic [7:0]              cur;
  function automatic logic [7:0] rev8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
  endfunction
  function automatic logic [CRC_W-1:0] revw(input logic [CRC_W-1:0] c);
    for (int i = 0; i < CRC_W; i++) revw[i] = c[CRC_W-1-i];
  endfunction
  function automatic logic [CRC_W-1:0] step(input logic [CRC_W-1:0] c, input logic [7:0] b);
    logic [CRC_W-1:0] r;
    r = c ^ (CRC_W'(b) << (CRC_W - 8));
    for (int i = 0; i < 8; i++) r = r[CRC_W-1] ? ((r << 1) ^ P) : (r << 1);
    return r;
  endfunction
  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN);
  // byte count of the incoming beat, selected byte and next register value
  always_comb begin
    n_in   = (in_eof && in_nbytes != '0 && in_nbytes <= NW'(DATA_BYTES)) ? in_nbytes : NW'(DATA_BYTES);
    cur    = data_q[8*idx_q +: 8];
    crc_nx = step(crc_q, (REFIN != 0) ? rev8(cur) : cur);
    last   = (idx_q + NW'(1) == n_q);
  end
  // frame FSM: accept a beat, fold its bytes one per cycle, publish the result on eof
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc_q     <= I0;
      in_frame  <= 1'b0;
      crc_valid <= 1'b0;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
      data_q    <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      eof_q     <= 1'b0;
      upd_q     <= 1'b0;
    end else if (in_abort) begin
      state     <= IDLE;
      in_frame  <= 1'b0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          data_q <= in_data;
          n_q    <= n_in;
          eof_q  <= in_eof;
          idx_q  <= '0;
          upd_q  <= in_sof || in_frame;
          state  <= RUN;
          if (in_sof) begin
            crc_q    <= I0;
            in_frame <= 1'b1;
          end
        end
        RUN: begin
          if (upd_q) crc_q <= crc_nx;
          idx_q <= idx_q + NW'(1);
          if (last) begin
            state <= (eof_q && upd_q) ? DONE : IDLE;
            if (eof_q && upd_q) begin
              crc_valid <= 1'b1;
              crc_out   <= ((REFOUT != 0) ? revw(crc_nx) : crc_nx) ^ XO;
              crc_ok    <= (crc_nx == RS);
            end
          end
        end
        DONE: begin
          in_frame <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_orlink_crc_engine.sv
// tb_orlink_crc_engine: randomized frames against a bit-serial CRC reference model
module tb_orlink_crc_engine;
  typedef logic [7:0] bq_t[$];
  typedef struct {logic [31:0] c0, c1, c2; logic k0, k1, k2;} exp_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        iv = 1'b0, isof = 1'b0, ieof = 1'b0, iab = 1'b0;
  logic [31:0] idata = '0;
  logic [2:0]  inb = '0;
  logic        rdy0, rdy1, rdy2, bz0, bz1, bz2, cv0, cv1, cv2, ok0, ok1, ok2;
  logic [15:0] co0, co1;
  logic [31:0] co2;
  logic        v1 = 1'b0, s1 = 1'b0, e1 = 1'b0, nb1 = 1'b0, ab1 = 1'b0;
  logic [7:0]  d1 = '0;
  logic        rdy3, bz3, cv3, ok3;
  logic [15:0] co3;
  int checks = 0, failures = 0, nres = 0, npush = 0;
  bit open = 1'b0;
  exp_t eq[$];

  always #5 clk = ~clk;

  orlink_crc_engine u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy0), .in_data(idata),
    .in_sof(isof), .in_eof(ieof), .in_nbytes(inb), .in_abort(iab), .busy(bz0), .crc_valid(cv0),
    .crc_out(co0), .crc_ok(ok0));
  orlink_crc_engine #(.POLY(32'h8005), .INIT(32'h0), .REFIN(1), .REFOUT(1)) u1 (.clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(rdy1), .in_data(idata), .in_sof(isof), .in_eof(ieof), .in_nbytes(inb),
    .in_abort(iab), .busy(bz1), .crc_valid(cv1), .crc_out(co1), .crc_ok(ok1));
  orlink_crc_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFIN(1), .REFOUT(1),
    .XOROUT(32'hFFFFFFFF)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy2), .in_data(idata),
    .in_sof(isof), .in_eof(ieof), .in_nbytes(inb), .in_abort(iab), .busy(bz2), .crc_valid(cv2),
    .crc_out(co2), .crc_ok(ok2));
  orlink_crc_engine #(.DATA_BYTES(1)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy3),
    .in_data(d1), .in_sof(s1), .in_eof(e1), .in_nbytes(nb1), .in_abort(ab1), .busy(bz3), .crc_valid(cv3),
    .crc_out(co3), .crc_ok(ok3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    return (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
  endfunction

  // textbook bit-at-a-time polynomial division over the message bit stream
  function automatic logic [31:0] raw_crc(input bq_t m, input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input bit refin);
    logic [31:0] r;
    bit fb;
    r = init & wmask(w);
    foreach (m[i])
      for (int j = 0; j < 8; j++) begin
        fb = r[w-1] ^ (refin ? m[i][j] : m[i][7-j]);
        r = (r << 1) & wmask(w);
        if (fb) r = r ^ (poly & wmask(w));
      end
    return r;
  endfunction

  function automatic logic [31:0] fin_crc(input logic [31:0] raw, input int w, input bit refout,
                                          input logic [31:0] xorout);
    logic [31:0] o;
    o = raw;
    if (refout) for (int i = 0; i < w; i++) o[i] = raw[w-1-i];
    return (o ^ xorout) & wmask(w);
  endfunction

  task automatic push_exp(input bq_t m);
    exp_t e;
    logic [31:0] r;
    r = raw_crc(m, 16, 32'h1021, 32'hFFFF, 1'b0);
    e.c0 = fin_crc(r, 16, 1'b0, 32'h0); e.k0 = (r == 32'h0);
    r = raw_crc(m, 16, 32'h8005, 32'h0, 1'b1);
    e.c1 = fin_crc(r, 16, 1'b1, 32'h0); e.k1 = (r == 32'h0);
    r = raw_crc(m, 32, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1);
    e.c2 = fin_crc(r, 32, 1'b1, 32'hFFFFFFFF); e.k2 = (r == 32'h0);
    eq.push_back(e);
    npush++;
  endtask

  task automatic wait_rdy();
    int k = 0;
    while (!rdy0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("rdy_timeout", 0, 1);
  endtask

  task automatic send_beat(input logic [31:0] d, input bit s, input bit e, input logic [2:0] nb);
    wait_rdy();
    iv = 1'b1; idata = d; isof = s; ieof = e; inb = nb;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0; isof = 1'b0; ieof = 1'b0;
  endtask

  task automatic send_frame(input bq_t m);
    logic [31:0] d;
    logic [2:0] nb;
    int n = m.size();
    push_exp(m);
    for (int i = 0; i < n; i += 4) begin
      d = $urandom;
      for (int b = 0; b < 4; b++) if (i + b < n) d[8*b +: 8] = m[i+b];
      nb = (i + 4 >= n) ? 3'(n - i) : 3'($urandom_range(0, 7));
      if (i + 4 >= n && nb == 3'd4 && $urandom_range(0, 1) == 1) nb = 3'd0;
      send_beat(d, i == 0, i + 4 >= n, nb);
    end
    open = 1'b0;
  endtask

  task automatic abort_pulse();
    iab = 1'b1;
    @(negedge clk);
    iab = 1'b0;
    open = 1'b0;
  endtask

  // every result strobe is matched against the oldest expected frame
  always @(negedge clk) if (rst_n && cv0) begin
    exp_t e;
    if (eq.size() == 0) chk("unexpected_valid", 1, 0);
    else begin
      e = eq.pop_front();
      nres++;
      chk("crc0", co0, e.c0); chk("ok0", ok0, e.k0);
      chk("valid1", cv1, 1);  chk("crc1", co1, e.c1); chk("ok1", ok1, e.k1);
      chk("valid2", cv2, 1);  chk("crc2", co2, e.c2); chk("ok2", ok2, e.k2);
    end
  end

  initial begin
    bq_t msg, m2;
    logic [31:0] c;
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bq_t msg, m2;
    logic [31:0] c;
    int len;
    msg = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy0, 1); chk("rst_busy", bz0, 0); chk("rst_valid", cv0, 0);
    chk("rst_crc", co0, 0);    chk("rst_ok", ok0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // single-byte beat on the 1-byte engine: latency and value
    v1 = 1'b1; d1 = 8'h41; s1 = 1'b1; e1 = 1'b1; nb1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    chk("db1_rdy_run", rdy3, 0); chk("db1_valid_run", cv3, 0); chk("db1_busy", bz3, 1);
    @(negedge clk);
    chk("db1_valid", cv3, 1); chk("db1_crc", co3, 16'hB915); chk("db1_rdy_done", rdy3, 0);
    @(negedge clk);
    chk("db1_rdy_back", rdy3, 1); chk("db1_valid_off", cv3, 0); chk("db1_crc_hold", co3, 16'hB915);
    // check value and residue frames
    send_frame(msg);
    wait_rdy();
    chk("check_crc16", co0, 16'h29B1); chk("check_ok", ok0, 0);
    chk("check_arc", co1, 16'hBB3D);   chk("check_crc32", co2, 32'hCBF43926);
    m2 = msg; m2.push_back(8'h29); m2.push_back(8'hB1);
    send_frame(m2);
    wait_rdy();
    chk("residue_crc", co0, 16'h0000); chk("residue_ok", ok0, 1);
    // back-to-back beats with valid held high
    iv = 1'b1; isof = 1'b1; ieof = 1'b0; idata = $urandom; inb = 3'd4;
    for (int k = 0; k < 10; k++) begin
      chk("tput_rdy", rdy0, (k % 5) == 0);
      @(posedge clk);
      @(negedge clk);
      isof = 1'b0;
    end
    iv = 1'b0;
    wait_rdy();
    abort_pulse();
    // beat outside a frame is dropped
    send_beat($urandom, 1'b0, 1'b1, 3'd4);
    send_frame(msg);
    wait_rdy();
    chk("after_drop", co0, 16'h29B1);
    // abort mid-frame
    send_beat(32'h34333231, 1'b1, 1'b0, 3'd4);
    abort_pulse();
    send_beat(32'h38373635, 1'b0, 1'b1, 3'd4);
    send_frame(msg);
    wait_rdy();
    chk("after_abort", co0, 16'h29B1);
    // reset during RUN
    send_beat(32'h34333231, 1'b1, 1'b0, 3'd4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", rdy0, 1); chk("mid_rst_busy", bz0, 0); chk("mid_rst_valid", cv0, 0);
    chk("mid_rst_crc", co0, 0);    chk("mid_rst_ok", ok0, 0);
    rst_n = 1'b1;
    open = 1'b0;
    // randomized mix of frames, partial frames, stray beats and aborts
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          len = $urandom_range(1, 13);
          m2 = {};
          for (int i = 0; i < len; i++) m2.push_back(8'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            c = fin_crc(raw_crc(m2, 16, 32'h1021, 32'hFFFF, 1'b0), 16, 1'b0, 32'h0);
            m2.push_back(c[15:8]); m2.push_back(c[7:0]);
          end
          send_frame(m2);
        end
        3: if (!open) send_beat($urandom, 1'b0, 1'($urandom), 3'($urandom_range(0, 7)));
        4: begin
          for (int k = $urandom_range(1, 2); k > 0; k--) send_beat($urandom, !open, 1'b0, 3'($urandom));
          open = 1'b1;
        end
        default: if (open) abort_pulse();
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (open) abort_pulse();
    wait_rdy();
    repeat (5) @(negedge clk);
    chk("pending", eq.size(), 0);
    chk("result_count", nres, npush);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
